// File: rtl/exp_align_stage.sv
// exp_align_stage: FP add/sub front end. Unpacks two operands, compares exponents and
// significands, swaps by magnitude and right-aligns the smaller significand with G/R/S.
module exp_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [EXP_W+MAN_W:0] OperandX,
  input  logic [EXP_W+MAN_W:0] OperandY,
  input  logic [1:0]           OpCode,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 SignOperandX,
  output logic                 SignOperandY,
  output logic                 EffOperation,
  output logic                 ExclusiveSign,
  output logic                 DSign,
  output logic                 DZF,
  output logic                 CMP1,
  output logic [EXP_W-1:0]     LargeExp,
  output logic [MAN_W:0]       LargeMan,
  output logic [MAN_W+3:0]     AlignedMan
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int AL_W   = MAN_W + 4;
  localparam int MAX_SH = MAN_W + 3;
  localparam int SH_W   = $clog2(MAX_SH + 1);

  typedef struct packed {
    logic             sx;
    logic             sy;
    logic             eff;
    logic             xsign;
    logic             dsign;
    logic             dzf;
    logic             cmp1;
    logic [EXP_W-1:0] large_exp;
    logic [SIG_W-1:0] large_man;
  } common_t;

  typedef struct packed {
    common_t          c;
    logic [SIG_W-1:0] small_man;
    logic [SH_W-1:0]  shamt;
  } stage_a_t;

  typedef struct packed {
    common_t         c;
    logic [AL_W-1:0] aligned;
  } stage_b_t;

  // Any distance past MAX_SH pushes every significand bit into sticky anyway.
  function automatic logic [SH_W-1:0] sat_shift(input logic [EXP_W:0] mag);
    if (mag > (EXP_W+1)'(MAX_SH)) return SH_W'(MAX_SH);
    return SH_W'(mag);
  endfunction

  function automatic logic [AL_W-1:0] align_shift(input logic [SIG_W-1:0] sig,
                                                  input logic [SH_W-1:0]  sh);
    logic [AL_W-1:0] ext;
    logic [AL_W-1:0] mask;
    ext  = {sig, 3'b000};
    mask = ~({AL_W{1'b1}} << sh);
    return (ext >> sh) | AL_W'(|(ext & mask));
  endfunction

  logic                    sx, sy;
  logic [EXP_W-1:0]        ex_raw, ey_raw, ex, ey;
  logic [SIG_W-1:0]        mx, my;
  logic signed [EXP_W:0]   diff;
  logic [EXP_W:0]          diff_mag;
  logic                    is_addsub, dsign, dzf, cmp1, swap;
  logic                    adv;
  logic                    vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  stage_a_t                a_p1_d, a_p1_q;
  stage_b_t                b_p2_d, b_p2_q;

  always_comb begin
    sx        = OperandX[EXP_W+MAN_W];
    sy        = OperandY[EXP_W+MAN_W];
    ex_raw    = OperandX[EXP_W+MAN_W-1 -: EXP_W];
    ey_raw    = OperandY[EXP_W+MAN_W-1 -: EXP_W];
    mx        = {|ex_raw, OperandX[MAN_W-1:0]};
    my        = {|ey_raw, OperandY[MAN_W-1:0]};
    // Denormals share the minimum normal exponent; only the hidden bit differs.
    ex        = (ex_raw == '0) ? EXP_W'(1) : ex_raw;
    ey        = (ey_raw == '0) ? EXP_W'(1) : ey_raw;
    diff      = $signed({1'b0, ex}) - $signed({1'b0, ey});
    dsign     = diff[EXP_W];
    dzf       = (diff == '0);
    cmp1      = (my > mx);
    diff_mag  = dsign ? $unsigned(-diff) : $unsigned(diff);
    is_addsub = ~OpCode[1];
    swap      = is_addsub & (dsign | (dzf & cmp1));
  end

  always_comb begin
    adv      = ~vld_p2_q | OutReady;
    vld_p1_d = adv ? InValid : vld_p1_q;
    vld_p2_d = adv ? vld_p1_q : vld_p2_q;

    // Stage A boundary: unpack, compare, swap decision, shift distance
    a_p1_d = a_p1_q;
    if (adv && InValid) begin
      a_p1_d.c.sx        = sx;
      a_p1_d.c.sy        = sy;
      a_p1_d.c.eff       = is_addsub & (OpCode[0] ^ sx ^ sy);
      a_p1_d.c.xsign     = sx ^ sy;
      a_p1_d.c.dsign     = dsign;
      a_p1_d.c.dzf       = dzf;
      a_p1_d.c.cmp1      = cmp1;
      a_p1_d.c.large_exp = swap ? ey : ex;
      a_p1_d.c.large_man = swap ? my : mx;
      a_p1_d.small_man   = swap ? mx : my;
      a_p1_d.shamt       = is_addsub ? sat_shift(diff_mag) : '0;
    end

    // Stage B boundary: alignment shift with sticky collection
    b_p2_d = b_p2_q;
    if (adv && vld_p1_q) begin
      b_p2_d.c       = a_p1_q.c;
      b_p2_d.aligned = align_shift(a_p1_q.small_man, a_p1_q.shamt);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      a_p1_q   <= '0;
      b_p2_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      a_p1_q   <= a_p1_d;
      b_p2_q   <= b_p2_d;
    end
  end

  assign InReady       = adv;
  assign OutValid      = vld_p2_q;
  assign SignOperandX  = b_p2_q.c.sx;
  assign SignOperandY  = b_p2_q.c.sy;
  assign EffOperation  = b_p2_q.c.eff;
  assign ExclusiveSign = b_p2_q.c.xsign;
  assign DSign         = b_p2_q.c.dsign;
  assign DZF           = b_p2_q.c.dzf;
  assign CMP1          = b_p2_q.c.cmp1;
  assign LargeExp      = b_p2_q.c.large_exp;
  assign LargeMan      = b_p2_q.c.large_man;
  assign AlignedMan    = b_p2_q.aligned;

endmodule

// File: tb/tb_exp_align_stage.sv
// Directed bench for exp_align_stage: hand-computed vectors, backpressure and async reset.
module tb_exp_align_stage;

  logic        Clk, Reset, InValid, InReady, OutValid, OutReady;
  logic [31:0] OperandX, OperandY;
  logic [1:0]  OpCode;
  logic        SignOperandX, SignOperandY, EffOperation, ExclusiveSign, DSign, DZF, CMP1;
  logic [7:0]  LargeExp;
  logic [23:0] LargeMan;
  logic [26:0] AlignedMan;
  logic [63:0] obs;

  int checks = 0;
  int failures = 0;

  exp_align_stage #(.EXP_W(8), .MAN_W(23)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .OperandX(OperandX), .OperandY(OperandY), .OpCode(OpCode),
    .OutValid(OutValid), .OutReady(OutReady),
    .SignOperandX(SignOperandX), .SignOperandY(SignOperandY),
    .EffOperation(EffOperation), .ExclusiveSign(ExclusiveSign),
    .DSign(DSign), .DZF(DZF), .CMP1(CMP1),
    .LargeExp(LargeExp), .LargeMan(LargeMan), .AlignedMan(AlignedMan)
  );

  // {DSign, DZF, CMP1, EffOperation, ExclusiveSign, LargeExp, LargeMan, AlignedMan}
  assign obs = {DSign, DZF, CMP1, EffOperation, ExclusiveSign, LargeExp, LargeMan, AlignedMan};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Present one op, let it be accepted, then wait (bounded) for OutValid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                        output int lat);
    @(negedge Clk);
    OperandX = x; OperandY = y; OpCode = op; InValid = 1'b1; OutReady = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    #1;
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
    checks++; if (obs !== 64'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++; if ({SignOperandX, SignOperandY} !== 2'b00) begin failures++; $display("FAIL reset_signs got=%b exp=00", {SignOperandX, SignOperandY}); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", InReady); end
  endtask

  task automatic test_add();
    int lat;
    logic [63:0] e;
    e = {5'b00000, 8'h80, 24'hC00000, 27'h2000000};
    run_op(32'h40400000, 32'h3F800000, 2'b00, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (obs !== e) begin failures++; $display("FAIL add_result got=%h exp=%h", obs, e); end
  endtask

  task automatic test_sub();
    int lat;
    logic [63:0] e;
    e = {5'b10010, 8'h82, 24'h800000, 27'h0800000};
    run_op(32'h3F800000, 32'h41000000, 2'b01, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sub_latency got=%0d exp=2", lat); end
    checks++; if (obs !== e) begin failures++; $display("FAIL sub_result got=%h exp=%h", obs, e); end
  endtask

  task automatic test_signs();
    int lat;
    logic [63:0] e;
    e = {5'b00011, 8'h80, 24'hC00000, 27'h2000000};
    run_op(32'hC0400000, 32'h3F800000, 2'b00, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL signs_add_result got=%h exp=%h", obs, e); end
    checks++; if ({SignOperandX, SignOperandY} !== 2'b10) begin failures++; $display("FAIL signs_add_signs got=%b exp=10", {SignOperandX, SignOperandY}); end
    e = {5'b00001, 8'h80, 24'hC00000, 27'h2000000};
    run_op(32'hC0400000, 32'h3F800000, 2'b01, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL signs_sub_result got=%h exp=%h", obs, e); end
  endtask

  task automatic test_equal_exp_and_mul();
    int lat;
    logic [63:0] e;
    e = {5'b01100, 8'h7F, 24'hC00000, 27'h4000000};
    run_op(32'h3F800000, 32'h3FC00000, 2'b00, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL eqexp_add_result got=%h exp=%h", obs, e); end
    e = {5'b01100, 8'h7F, 24'h800000, 27'h6000000};
    run_op(32'h3F800000, 32'h3FC00000, 2'b10, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL eqexp_mul_result got=%h exp=%h", obs, e); end
    e = {5'b10000, 8'h7F, 24'h800000, 27'h4000000};
    run_op(32'h3F800000, 32'h41000000, 2'b11, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL div_noswap_result got=%h exp=%h", obs, e); end
  endtask

  task automatic test_sticky();
    int lat;
    logic [63:0] e;
    e = {5'b00100, 8'h96, 24'h800000, 27'h0000009};
    run_op(32'h4B000000, 32'h3F800001, 2'b00, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL sticky_result got=%h exp=%h", obs, e); end
    e = {5'b00000, 8'hA0, 24'h800000, 27'h0000001};
    run_op(32'h50000000, 32'h3F800000, 2'b00, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL saturate_result got=%h exp=%h", obs, e); end
    e = {5'b01100, 8'h01, 24'h800000, 27'h0000018};
    run_op(32'h00000003, 32'h00800000, 2'b00, lat);
    checks++; if (obs !== e) begin failures++; $display("FAIL denormal_result got=%h exp=%h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vx[4];
    logic [31:0] vy[4];
    logic [1:0]  vo[4];
    logic [63:0] ve[4];
    logic [63:0] snap;
    int sent, rcvd, stall;
    bit seen;
    vx = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    vy = '{32'h3F800000, 32'h41000000, 32'h3FC00000, 32'h3FC00000};
    vo = '{2'b00, 2'b01, 2'b00, 2'b10};
    ve[0] = {5'b00000, 8'h80, 24'hC00000, 27'h2000000};
    ve[1] = {5'b10010, 8'h82, 24'h800000, 27'h0800000};
    ve[2] = {5'b01100, 8'h7F, 24'hC00000, 27'h4000000};
    ve[3] = {5'b01100, 8'h7F, 24'h800000, 27'h6000000};
    sent = 0; rcvd = 0; stall = 0; seen = 0; snap = '0;
    for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
      @(negedge Clk);
      if (OutValid && !seen) begin
        seen = 1; stall = 3; snap = obs;
      end
      OutReady = (stall == 0);
      InValid  = (sent < 4);
      if (sent < 4) begin
        OperandX = vx[sent]; OperandY = vy[sent]; OpCode = vo[sent];
      end
      #1;
      if (stall > 0) begin
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL bp_inready_stall got=%b exp=0", InReady); end
        if (stall < 3) begin
          checks++; if (OutValid !== 1'b1 || obs !== snap) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", OutValid, obs, snap); end
        end
        stall--;
      end
      if (OutValid && OutReady) begin
        checks++; if (obs !== ve[rcvd]) begin failures++; $display("FAIL bp_out%0d got=%h exp=%h", rcvd, obs, ve[rcvd]); end
        rcvd++;
      end
      if (InValid && InReady) sent++;
    end
    InValid = 1'b0; OutReady = 1'b1;
    checks++; if (rcvd !== 4 || sent !== 4) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=4/4", sent, rcvd); end
    @(negedge Clk);
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", OutValid); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    logic [63:0] e;
    @(negedge Clk);
    OutReady = 1'b1; InValid = 1'b1; OpCode = 2'b00;
    OperandX = 32'h40400000; OperandY = 32'h3F800000;
    @(negedge Clk);
    OperandX = 32'h3F800000; OperandY = 32'h3FC00000;
    @(negedge Clk);
    InValid = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_outvalid got=%b exp=0", OutValid); end
    checks++; if (obs !== 64'h0 || {SignOperandX, SignOperandY} !== 2'b00) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", obs); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL midrst_inready got=%b exp=1", InReady); end
    @(negedge Clk);
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b exp=0", OutValid); end
    e = {5'b10010, 8'h82, 24'h800000, 27'h0800000};
    run_op(32'h3F800000, 32'h41000000, 2'b01, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL midrst_latency got=%0d exp=2", lat); end
    checks++; if (obs !== e) begin failures++; $display("FAIL midrst_result got=%h exp=%h", obs, e); end
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    OperandX = '0; OperandY = '0; OpCode = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_signs();
    test_equal_exp_and_mul();
    test_sticky();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp_align_stage.md
Name: exp_align_stage

Overview:
- Front-end pipeline stage of the FP add/sub path, directly upstream of the sign-resolution stage.
- Takes two IEEE-754 single-precision operands and an opcode, then unpacks them and compares exponents and mantissas.
- Swaps so the larger-magnitude operand is "large", and right-aligns the smaller mantissa with guard/round/sticky bits.
- Registers every control flag the sign stage consumes (DSign, DZF, CMP1, EffOperation, ExclusiveSign, operand signs) alongside the aligned data, through a 2-stage valid/ready pipeline.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (significand = MAN_W+1 with hidden bit)

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
InValid  in  1  input operands valid
InReady  out  1  stage can accept input this cycle
OperandX  in  EXP_W+MAN_W+1  first operand (sign, exponent, fraction)
OperandY  in  EXP_W+MAN_W+1  second operand
OpCode  in  2  00 add, 01 sub, 10 mul, 11 div
OutValid  out  1  outputs valid
OutReady  in  1  downstream accepts this cycle
SignOperandX  out  1  sign of X
SignOperandY  out  1  sign of Y
EffOperation  out  1  1 = effective subtraction
ExclusiveSign  out  1  SignX ^ SignY
DSign  out  1  1 iff Ey > Ex
DZF  out  1  1 iff Ex == Ey
CMP1  out  1  1 iff My > Mx (significands incl. hidden bit)
LargeExp  out  EXP_W  effective exponent of larger-magnitude operand
LargeMan  out  MAN_W+1  significand of larger-magnitude operand
AlignedMan  out  MAN_W+4  smaller significand right-shifted: {sig, G, R, S}

Behaviour:
- Reset is asynchronous, active-high. While asserted, both stage-valid bits are 0, OutValid=0, and all data/flag outputs are 0. InReady=1 after reset. Any in-flight operations are discarded with no partial output.
- Handshake: the pipeline advances iff Advance = ~OutValid | OutReady. InReady = Advance.
  - An input transfers when InValid & InReady.
  - An output transfers when OutValid & OutReady.
  - On stall, both stages hold their contents and outputs stay stable.
  - Bubbles propagate as valid=0.
- Latency is exactly 2 cycles with no stall; throughput is 1 op/cycle.
- Stage A (registered at end of the accept cycle):
  - Unpack. Hidden bit = (exp != 0). Effective exponent = max(exp, 1), so denormals are handled.
  - Compute Ex-Ey to EXP_W+1 bits. DSign = borrow. DZF = (difference == 0). CMP1 = (My > Mx).
  - Swap = DSign | (DZF & CMP1).
  - Shift amount = |Ex-Ey|, saturated to MAN_W+3.
  - ExclusiveSign = SX ^ SY.
  - EffOperation = (OpCode == 01) ^ SX ^ SY for add/sub. EffOperation = 0 for mul/div.
- Stage B:
  - Take the smaller significand, extended with 3 zero bits ({sig, 000}), and logically right-shift it by the shift amount.
  - S (LSB) = OR of the shifted-in sticky position and all bits shifted out.
  - A saturated shift yields 0 except S = (small significand != 0).
- Mul/div ops:
  - Swap is forced to 0 and shift to 0: LargeExp/LargeMan come from X, AlignedMan = {My, 000}.
  - DSign/DZF/CMP1 are still computed from the operands.
- No special handling of Inf/NaN/zero. Exponent 255 is treated numerically; special cases are flagged by a separate path.
- Simultaneous input accept and output consume in the same cycle are legal and must not drop or duplicate data.

Test Plan:
- Add, X=0x40400000 (3.0), Y=0x3F800000 (1.0) -> after 2 cycles: DSign=0, DZF=0, CMP1=0, EffOperation=0, LargeExp=0x80, LargeMan=0xC00000, AlignedMan=0x2000000.
- Sub, X=0x3F800000, Y=0x41000000 (8.0) -> DSign=1, EffOperation=1, ExclusiveSign=0, LargeExp=0x82, LargeMan=0x800000, AlignedMan=0x0800000.
- Equal exponents, add, X=0x3F800000, Y=0x3FC00000 -> DZF=1, CMP1=1, DSign=0, LargeMan=0xC00000, AlignedMan=0x4000000. Then mul with the same operands -> no swap: LargeMan=0x800000, AlignedMan=0x6000000, EffOperation=0.
- Sticky/saturation: X=0x4B000000, Y=0x3F800001 add -> AlignedMan=0x0000009. Then X=0x50000000, Y=0x3F800000 (diff 33) -> AlignedMan=0x0000001.
- Backpressure: stream 4 ops back-to-back, hold OutReady=0 for 3 cycles after first OutValid -> InReady=0 during stall, outputs stable, all 4 results delivered in order, none lost or duplicated.
- Reset asserted mid-stream with 2 ops in flight -> OutValid=0 and all outputs 0 immediately (async). After release, InReady=1 and the first new op appears 2 cycles after acceptance.
